alsu_cmd_driver: RTL and testbench

Command-side initiator for the ALSU. It accepts tagged ALSU operations over a valid/ready command port and buffers them in a small FIFO. It drives the ALSU input pins one operation at a time, waits out the ALSU's two-register pipeline, and captures `out`. It returns the result on a valid/ready response port with a predicted-invalid flag. It sits between a test/host sequencer and one ALSU instance.

---
 rtl/alsu_drv_pkg.sv | 52 +++++
 rtl/alsu_cmd_fifo.sv | 51 +++++
 rtl/alsu_cmd_driver.sv | 176 +++++++++++++++++
 tb/tb_alsu_cmd_driver.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alsu_drv_pkg.sv
// rtl/alsu_drv_pkg.sv - Shared types and helpers for the ALSU command driver
package alsu_drv_pkg;

    // Tag field width carried through the command FIFO; the top-level TAG_W must not exceed it.
    localparam int CMD_TAG_W = 4;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        CAPTURE,
        RESP
    } drv_state_e;

    typedef enum logic [2:0] {
        OR     = 3'd0,
        XOR    = 3'd1,
        ADD    = 3'd2,
        MULT   = 3'd3,
        SHIFT  = 3'd4,
        ROTATE = 3'd5,
        INV6   = 3'd6,
        INV7   = 3'd7
    } alsu_opcode_e;

    typedef struct packed {
        alsu_opcode_e          opcode;
        logic [2:0]            a;
        logic [2:0]            b;
        logic                  cin;
        logic                  serial_in;
        logic                  direction;
        logic                  red_op_a;
        logic                  red_op_b;
        logic                  bypass_a;
        logic                  bypass_b;
        logic [CMD_TAG_W-1:0]  tag;
    } alsu_cmd_t;

    // Bypass wins over everything; otherwise reductions only make sense for OR/XOR and 6/7 are never legal.
    function automatic logic predict_invalid(
        input logic [2:0] op,
        input logic       red_op_a,
        input logic       red_op_b,
        input logic       bypass_a,
        input logic       bypass_b
    );
        return !(bypass_a | bypass_b) &
               (((red_op_a | red_op_b) & (op[1] | op[2])) | (op[1] & op[2]));
    endfunction

endpackage

// File: rtl/alsu_cmd_fifo.sv
// rtl/alsu_cmd_fifo.sv - Synchronous FIFO of ALSU commands
module alsu_cmd_fifo
    import alsu_drv_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      push,
    input  alsu_cmd_t push_data,
    input  logic      pop,
    output alsu_cmd_t pop_data,
    output logic      full,
    output logic      empty
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] PTR_ONE = 1;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [PW:0] wr_ptr;
    logic [PW:0] rd_ptr;
    alsu_cmd_t   mem [DEPTH];

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign pop_data = mem[rd_ptr[PW-1:0]];

    // Storage array: written on accepted push, contents need no reset.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wr_ptr[PW-1:0]] <= push_data;
        end
    end

    // Pointer update; reset flushes the queue.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

endmodule

// File: rtl/alsu_cmd_driver.sv
// rtl/alsu_cmd_driver.sv - Queues ALSU commands, drives the ALSU pins and returns tagged results
module alsu_cmd_driver
    import alsu_drv_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int TAG_W      = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_opcode,
    input  logic [2:0]       cmd_a,
    input  logic [2:0]       cmd_b,
    input  logic             cmd_cin,
    input  logic             cmd_serial_in,
    input  logic             cmd_direction,
    input  logic             cmd_red_op_a,
    input  logic             cmd_red_op_b,
    input  logic             cmd_bypass_a,
    input  logic             cmd_bypass_b,
    input  logic [TAG_W-1:0] cmd_tag,
    output logic [2:0]       opcode,
    output logic [2:0]       A,
    output logic [2:0]       B,
    output logic             cin,
    output logic             serial_in,
    output logic             direction,
    output logic             red_op_A,
    output logic             red_op_B,
    output logic             bypass_A,
    output logic             bypass_B,
    input  logic [5:0]       alsu_out,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [5:0]       rsp_data,
    output logic             rsp_invalid,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             busy
);

    drv_state_e state;
    drv_state_e state_next;
    alsu_cmd_t  push_cmd;
    alsu_cmd_t  head_cmd;
    logic       fifo_full;
    logic       fifo_empty;
    logic       pop;
    logic       capture;
    logic       rsp_done;

    assign cmd_ready = !fifo_full && !rst;
    assign busy      = (state != IDLE) || !fifo_empty;

    // Pack the command port into the queued record.
    always_comb begin
        push_cmd           = '0;
        push_cmd.opcode    = alsu_opcode_e'(cmd_opcode);
        push_cmd.a         = cmd_a;
        push_cmd.b         = cmd_b;
        push_cmd.cin       = cmd_cin;
        push_cmd.serial_in = cmd_serial_in;
        push_cmd.direction = cmd_direction;
        push_cmd.red_op_a  = cmd_red_op_a;
        push_cmd.red_op_b  = cmd_red_op_b;
        push_cmd.bypass_a  = cmd_bypass_a;
        push_cmd.bypass_b  = cmd_bypass_b;
        push_cmd.tag       = CMD_TAG_W'(cmd_tag);
    end

    alsu_cmd_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (cmd_valid && cmd_ready),
        .push_data (push_cmd),
        .pop       (pop),
        .pop_data  (head_cmd),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state plus pop/capture/release strobes; two idle cycles cover the ALSU's pin and output registers.
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        capture    = 1'b0;
        rsp_done   = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE:   state_next = WAIT;
            WAIT:    state_next = CAPTURE;
            CAPTURE: begin
                capture    = 1'b1;
                state_next = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_done = 1'b1;
                    if (!fifo_empty) begin
                        pop        = 1'b1;
                        state_next = ISSUE;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // ALSU pin registers: loaded on pop and otherwise held, so shift/rotate keeps stepping between ops.
    always_ff @(posedge clk) begin
        if (rst) begin
            opcode    <= '0;
            A         <= '0;
            B         <= '0;
            cin       <= 1'b0;
            serial_in <= 1'b0;
            direction <= 1'b0;
            red_op_A  <= 1'b0;
            red_op_B  <= 1'b0;
            bypass_A  <= 1'b0;
            bypass_B  <= 1'b0;
        end else if (pop) begin
            opcode    <= head_cmd.opcode;
            A         <= head_cmd.a;
            B         <= head_cmd.b;
            cin       <= head_cmd.cin;
            serial_in <= head_cmd.serial_in;
            direction <= head_cmd.direction;
            red_op_A  <= head_cmd.red_op_a;
            red_op_B  <= head_cmd.red_op_b;
            bypass_A  <= head_cmd.bypass_a;
            bypass_B  <= head_cmd.bypass_b;
        end
    end

    // Response registers: tag and invalid prediction latched at issue, data at capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid   <= 1'b0;
            rsp_data    <= '0;
            rsp_invalid <= 1'b0;
            rsp_tag     <= '0;
        end else begin
            if (pop) begin
                rsp_tag     <= TAG_W'(head_cmd.tag);
                rsp_invalid <= predict_invalid(head_cmd.opcode, head_cmd.red_op_a, head_cmd.red_op_b,
                                               head_cmd.bypass_a, head_cmd.bypass_b);
            end
            if (capture) begin
                rsp_data  <= alsu_out;
                rsp_valid <= 1'b1;
            end else if (rsp_done) begin
                rsp_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alsu_cmd_driver.sv
// tb/tb_alsu_cmd_driver.sv - Self-checking bench for alsu_cmd_driver with an ALSU stand-in
module tb_alsu_cmd_driver;

    typedef struct {
        logic [2:0] op;
        logic [2:0] a;
        logic [2:0] b;
        logic       cin;
        logic       sin;
        logic       dir;
        logic       ra;
        logic       rb;
        logic       ba;
        logic       bb;
        logic [3:0] tag;
    } tcmd_t;

    typedef struct {
        int         data;
        logic       inv;
        logic [3:0] tag;
    } texp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       cmd_valid;
    logic       rsp_ready;
    tcmd_t      cur;
    logic       cmd_ready;
    logic [2:0] pin_op, pin_a, pin_b;
    logic       pin_cin, pin_sin, pin_dir, pin_ra, pin_rb, pin_ba, pin_bb;
    logic [5:0] alsu_out;
    logic       rsp_valid;
    logic [5:0] rsp_data;
    logic       rsp_invalid;
    logic [3:0] rsp_tag;
    logic       busy;

    alsu_cmd_driver #(.FIFO_DEPTH(4), .TAG_W(4)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_opcode(cur.op), .cmd_a(cur.a), .cmd_b(cur.b), .cmd_cin(cur.cin),
        .cmd_serial_in(cur.sin), .cmd_direction(cur.dir), .cmd_red_op_a(cur.ra),
        .cmd_red_op_b(cur.rb), .cmd_bypass_a(cur.ba), .cmd_bypass_b(cur.bb), .cmd_tag(cur.tag),
        .opcode(pin_op), .A(pin_a), .B(pin_b), .cin(pin_cin), .serial_in(pin_sin),
        .direction(pin_dir), .red_op_A(pin_ra), .red_op_B(pin_rb), .bypass_A(pin_ba),
        .bypass_B(pin_bb), .alsu_out(alsu_out), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_invalid(rsp_invalid), .rsp_tag(rsp_tag), .busy(busy)
    );

    // ALSU stand-in: input register stage then output register stage (FULL_ADDER on, priority A).
    logic [2:0] r_op, r_a, r_b;
    logic       r_cin, r_sin, r_dir, r_ra, r_rb, r_ba, r_bb;

    function automatic logic [5:0] alsu_eval(input logic [2:0] op, input logic [2:0] a, input logic [2:0] b,
                                             input logic ci, input logic si, input logic dr, input logic ra,
                                             input logic rb, input logic ba, input logic bb, input logic [5:0] q);
        logic [5:0] ea;
        logic [5:0] eb;
        ea = {{3{a[2]}}, a};
        eb = {{3{b[2]}}, b};
        if (ba) return ea;
        if (bb) return eb;
        if (((ra | rb) && op[2:1] != 2'b00) || op[2:1] == 2'b11) return 6'd0;
        case (op)
            3'd0:    return ra ? {5'd0, |a} : (rb ? {5'd0, |b} : (ea | eb));
            3'd1:    return ra ? {5'd0, ^a} : (rb ? {5'd0, ^b} : (ea ^ eb));
            3'd2:    return ea + eb + {5'd0, ci};
            3'd3:    return ea * eb;
            3'd4:    return dr ? {q[4:0], si} : {si, q[5:1]};
            3'd5:    return dr ? {q[4:0], q[5]} : {q[0], q[5:1]};
            default: return 6'd0;
        endcase
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            {r_op, r_a, r_b, r_cin, r_sin, r_dir, r_ra, r_rb, r_ba, r_bb} <= '0;
            alsu_out <= 6'd0;
        end else begin
            {r_op, r_a, r_b} <= {pin_op, pin_a, pin_b};
            {r_cin, r_sin, r_dir, r_ra, r_rb, r_ba, r_bb} <= {pin_cin, pin_sin, pin_dir, pin_ra, pin_rb, pin_ba, pin_bb};
            alsu_out <= alsu_eval(r_op, r_a, r_b, r_cin, r_sin, r_dir, r_ra, r_rb, r_ba, r_bb, alsu_out);
        end
    end

    // Reference model: integer arithmetic on the command fields.
    function automatic logic ref_invalid(input tcmd_t c);
        if (c.ba || c.bb) return 1'b0;
        return (c.op >= 3'd6) || ((c.op >= 3'd2) && (c.ra || c.rb));
    endfunction

    function automatic logic ref_moving(input tcmd_t c);
        return !c.ba && !c.bb && !ref_invalid(c) && (c.op == 3'd4 || c.op == 3'd5);
    endfunction

    // prev is the ALSU output left by the previously issued (non-moving) command.
    function automatic int ref_data(input tcmd_t c, input int prev);
        int sa;
        int sb;
        sa = int'($signed(c.a));
        sb = int'($signed(c.b));
        if (c.ba) return sa & 63;
        if (c.bb) return sb & 63;
        if (ref_invalid(c)) return 0;
        case (c.op)
            3'd0:    return c.ra ? int'(c.a != 0) : (c.rb ? int'(c.b != 0) : ((sa | sb) & 63));
            3'd1:    return c.ra ? ($countones(c.a) % 2) : (c.rb ? ($countones(c.b) % 2) : ((sa ^ sb) & 63));
            3'd2:    return (sa + sb + int'(c.cin)) & 63;
            3'd3:    return (sa * sb) & 63;
            3'd4:    return c.dir ? ((prev * 2 + int'(c.sin)) % 64) : (int'(c.sin) * 32 + prev / 2);
            3'd5:    return c.dir ? ((prev * 2) % 64 + prev / 32) : ((prev % 2) * 32 + prev / 2);
            default: return 0;
        endcase
    endfunction

    function automatic tcmd_t mk(input logic [2:0] op, input logic [2:0] a, input logic [2:0] b,
                                 input logic [6:0] ctl, input logic [3:0] tag);
        tcmd_t c;
        c.op = op; c.a = a; c.b = b; c.tag = tag;
        {c.cin, c.sin, c.dir, c.ra, c.rb, c.ba, c.bb} = ctl;
        return c;
    endfunction

    // A shift/rotate following another shift/rotate depends on free-running cycles, so avoid that pairing.
    function automatic tcmd_t rand_cmd(input logic [3:0] tag, input logic no_move);
        tcmd_t c;
        c.op  = 3'($urandom_range(0, 7));
        c.a   = 3'($urandom);
        c.b   = 3'($urandom);
        c.cin = 1'($urandom);
        c.sin = 1'($urandom);
        c.dir = 1'($urandom);
        c.ra  = ($urandom_range(0, 3) == 0);
        c.rb  = ($urandom_range(0, 3) == 0);
        c.ba  = ($urandom_range(0, 5) == 0);
        c.bb  = ($urandom_range(0, 5) == 0);
        c.tag = tag;
        if (no_move && ref_moving(c)) c.op = 3'($urandom_range(0, 3));
        return c;
    endfunction

    int         n_cmp = 0;
    int         n_fail = 0;
    int         rsp_count = 0;
    int         prev_val = 0;
    logic       prev_move = 1'b0;
    logic       last_cf = 1'b0;
    texp_t      exp_q[$];
    logic [3:0] rsp_tags[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // One clock: record handshakes seen at the negedge, step through the posedge, land on the next negedge.
    task automatic cycle();
        logic  rf;
        logic  rn;
        texp_t e;
        rn      = rst;
        last_cf = cmd_valid && cmd_ready;
        rf      = rsp_valid && rsp_ready && !rst;
        if (last_cf) begin
            e.data = ref_data(cur, prev_val);
            e.inv  = ref_invalid(cur);
            e.tag  = cur.tag;
            exp_q.push_back(e);
            prev_val  = e.data;
            prev_move = ref_moving(cur);
        end
        if (rf) begin
            check("rsp_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("rsp_data", 32'(rsp_data), e.data);
                check("rsp_invalid", 32'(rsp_invalid), 32'(e.inv));
                check("rsp_tag", 32'(rsp_tag), 32'(e.tag));
            end
            rsp_count++;
            rsp_tags.push_back(rsp_tag);
        end
        @(posedge clk);
        if (rn) begin
            exp_q.delete();
            prev_val  = 0;
            prev_move = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic run_directed(input string name, input tcmd_t c, input int exp_data, input logic exp_inv);
        int t;
        cur = c;
        cmd_valid = 1'b1;
        t = 0;
        do begin
            cycle();
            t++;
        end while (!last_cf && t < 20);
        cmd_valid = 1'b0;
        check({name, "_accept"}, 32'(last_cf), 32'd1);
        t = 0;
        while (!rsp_valid && t < 20) begin
            cycle();
            t++;
        end
        check({name, "_latency"}, t, 32'd4);
        check({name, "_data"}, 32'(rsp_data), exp_data);
        check({name, "_invalid"}, 32'(rsp_invalid), 32'(exp_inv));
        check({name, "_tag"}, 32'(rsp_tag), 32'(c.tag));
        cycle();
    endtask

    initial begin
        int acc;
        int base;
        int t;
        logic [3:0] tagctr;

        rst = 1'b1;
        cmd_valid = 1'b0;
        rsp_ready = 1'b0;
        cur = mk(3'd0, 3'd0, 3'd0, 7'd0, 4'd0);
        repeat (3) cycle();
        check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        check("rst_pins", 32'({pin_op, pin_a, pin_b, pin_cin, pin_sin, pin_dir, pin_ra, pin_rb, pin_ba, pin_bb}), 32'd0);
        check("rst_rsp", 32'({rsp_valid, rsp_data, rsp_invalid, rsp_tag}), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        #1;
        check("cmd_ready_after_rst", 32'(cmd_ready), 32'd1);

        // Directed operations; control bits are {cin, serial_in, direction, red_a, red_b, bypass_a, bypass_b}.
        rsp_ready = 1'b1;
        run_directed("add",    mk(3'd2, 3'd3, 3'd2, 7'b1000000, 4'd1), 6'b000110, 1'b0);
        run_directed("mult",   mk(3'd3, 3'b110, 3'd3, 7'b0000000, 4'd2), 6'b111010, 1'b0);
        run_directed("red_or", mk(3'd0, 3'b100, 3'd0, 7'b0001000, 4'd3), 6'b000001, 1'b0);
        run_directed("inv6",   mk(3'd6, 3'd3, 3'd3, 7'b0000000, 4'd4), 6'b000000, 1'b1);
        run_directed("bypass", mk(3'd7, 3'd0, 3'b111, 7'b0000001, 4'd5), 6'b111111, 1'b0);
        run_directed("shift",  mk(3'd4, 3'd0, 3'd0, 7'b0010000, 4'd6), 6'b111110, 1'b0);
        run_directed("add2",   mk(3'd2, 3'd1, 3'd1, 7'b0000000, 4'd7), 6'b000010, 1'b0);
        run_directed("rotate", mk(3'd5, 3'd0, 3'd0, 7'b0000000, 4'd8), 6'b000001, 1'b0);

        // Backpressure: with responses stalled, the FIFO plus the in-flight op hold five commands.
        rsp_ready = 1'b0;
        acc = 0;
        base = rsp_count;
        rsp_tags.delete();
        cur = rand_cmd(4'd0, prev_move);
        cmd_valid = 1'b1;
        repeat (12) begin
            cycle();
            if (last_cf) begin
                acc++;
                if (acc < 6) cur = rand_cmd(4'(acc), prev_move);
                else cmd_valid = 1'b0;
            end
        end
        check("bp_accepted", acc, 32'd5);
        check("bp_cmd_ready", 32'(cmd_ready), 32'd0);
        check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
        rsp_ready = 1'b1;
        t = 0;
        while ((rsp_count - base) < 6 && t < 100) begin
            cycle();
            t++;
            if (last_cf) begin
                acc++;
                cmd_valid = 1'b0;
            end
        end
        check("bp_rsp_total", rsp_count - base, 32'd6);
        for (int i = 0; i < 6; i++) begin
            check("bp_tag_order", (i < rsp_tags.size()) ? 32'(rsp_tags[i]) : 32'hffff, i);
        end

        // Randomized traffic with random response stalls.
        tagctr = 4'd0;
        cur = rand_cmd(tagctr, prev_move);
        cmd_valid = 1'b1;
        repeat (400) begin
            rsp_ready = ($urandom_range(0, 3) != 0);
            cycle();
            if (last_cf || !cmd_valid) begin
                tagctr = tagctr + 4'd1;
                cur = rand_cmd(tagctr, prev_move);
                cmd_valid = ($urandom_range(0, 2) != 0);
            end
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        t = 0;
        while ((exp_q.size() != 0 || rsp_valid) && t < 200) begin
            cycle();
            t++;
        end
        check("drain_empty", exp_q.size(), 32'd0);
        check("drain_idle", 32'(busy), 32'd0);

        // Reset while the first of three queued commands sits in WAIT.
        cmd_valid = 1'b1;
        cur = mk(3'd3, 3'd5, 3'd6, 7'b1111111, 4'd10);
        cycle();
        cur = mk(3'd2, 3'd1, 3'd2, 7'b0000000, 4'd11);
        cycle();
        cur = mk(3'd1, 3'd3, 3'd4, 7'b0000000, 4'd12);
        cycle();
        cmd_valid = 1'b0;
        check("pre_rst_busy", 32'(busy), 32'd1);
        base = rsp_count;
        rst = 1'b1;
        cycle();
        check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("midrst_pins", 32'({pin_op, pin_a, pin_b, pin_cin, pin_sin, pin_dir, pin_ra, pin_rb, pin_ba, pin_bb}), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        repeat (20) cycle();
        check("flushed_no_rsp", rsp_count - base, 32'd0);
        check("flushed_idle", 32'(busy), 32'd0);
        check("final_queue", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
